// File: rtl/sync_fifo_pkg.sv
// Package: sync_fifo_pkg
// Shared helpers for the sync_fifo_param FIFO:
//   addr_width() - ceil(log2(depth)), minimum 1, for sizing pointer and address fields
//   ERR_OVF/ERR_UNF - bit positions of the sticky error flags when packed into a status word
package sync_fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Interface: sync_fifo_param_if
// Bundles the FIFO's data, handshake and status signals.
//   master modport - producer/consumer side: drives wr, data_in, rd, flush, clr_err
//   slave modport  - FIFO side: drives data_out, rd_valid, flags, count and error flags
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();

  localparam int AW = addr_width(DEPTH);

  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             flush;
  logic             clr_err;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd, flush, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd, flush, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_fifo_ram.sv
// Module: fifo_ram
// Simple dual-port register array, WIDTH x DEPTH: one synchronous write port,
// one asynchronous read port. Contents are never reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Module: sync_fifo_param
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// flags, sticky overflow/underflow flags and synchronous flush.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - sync_fifo_param_if.slave (wr, data_in, rd, data_out, rd_valid,
//           flush, clr_err, full, empty, almost_full, almost_empty, count,
//           overflow, underflow)
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word whenever not empty, rd acknowledges it).
// Without it, reads are registered with one cycle of latency.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst_n,
  sync_fifo_param_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  // Illegal configurations stop elaboration.
  if (!(WIDTH >= 1 && DEPTH >= 4 && (DEPTH & (DEPTH - 1)) == 0 &&
        AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_cfg_bad
    $fatal(1, "sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg, af_reg, ae_reg;
  logic [1:0]       err_reg, err_set, err_next;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags from the start of the cycle;
  // flush overrides both requests.
  assign wr_acc = bus.wr && !full_reg  && !bus.flush;
  assign rd_acc = bus.rd && !empty_reg && !bus.flush;

  always_comb begin
    count_next = count_reg;
    if (bus.flush) begin
      count_next = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + ONE_C;
        2'b01:   count_next = count_reg - ONE_C;
        default: count_next = count_reg;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = bus.wr && full_reg  && !bus.flush;
    err_set[ERR_UNF] = bus.rd && empty_reg && !bus.flush;
    err_next         = err_set | (bus.clr_err ? 2'b00 : err_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      err_reg    <= '0;
    end else begin
      if (bus.flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_acc) wr_ptr_reg <= wr_ptr_reg + ONE_C;
        if (rd_acc) rd_ptr_reg <= rd_ptr_reg + ONE_C;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
      err_reg   <= err_next;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd only advances the read pointer.
  assign bus.data_out = ram_rdata;
  assign bus.rd_valid = !empty_reg;
`else
  logic [WIDTH-1:0] data_out_reg;
  logic             rd_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) data_out_reg <= ram_rdata;
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.rd_valid = rd_valid_reg;
`endif

  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = err_reg[ERR_OVF];
  assign bus.underflow    = err_reg[ERR_UNF];

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 8-bit × 16 FIFO memory.
- Generalised in data width and depth.
- Adds simultaneous read/write, a fill-level output, programmable almost-full/almost-empty flags, sticky error flags with clear, and synchronous flush.
- Sits between producer/consumer datapath stages on one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; power of two, >=4
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr  input  1  write request
data_in  input  WIDTH  write data
rd  input  1  read request
data_out  output  WIDTH  read data
rd_valid  output  1  data_out holds a newly popped word
flush  input  1  synchronous clear of contents
clr_err  input  1  clears sticky error flags
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  AW+1  current fill level, AW = clog2(DEPTH)
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset is fixed as one clock, clk; asynchronous active-low reset, rst_n.
- Reset clears: pointers, count, data_out, rd_valid, overflow and underflow, all to 0. Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0.
- Storage contents are not reset. A reset mid-operation discards all data immediately.
- Pointers are AW+1 bits wide and wrap naturally; the MSB distinguishes full from empty. count is a separate registered counter.
- Write is accepted iff wr && !full. Read is accepted iff rd && !empty. full and empty are the registered state at the start of the cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- When full with both wr and rd: only the read is accepted; the write is dropped and overflow is set.
- When empty with both wr and rd: only the write is accepted; the read is dropped and underflow is set.
- Default (registered) read: on an accepted read, data_out <= mem[rd_ptr] and rd_valid=1 the next cycle, i.e. 1-cycle latency.
- rd_valid is 0 in cycles without an accepted read. data_out holds its last value; it is never driven to X.
- Write-to-read latency: a word written in cycle N is readable in cycle N+1. empty deasserts at N+1.
- Flags and count are registered and update the cycle after the causing edge.
- Sticky flags:
  - overflow is set by wr && full; underflow is set by rd && empty.
  - Both hold until clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- flush=1 has priority over rd and wr. It zeroes pointers and count next cycle and forces rd_valid=0. Sticky flags and data_out are kept.
- Configurations violating AE_LEVEL < AF_LEVEL <= DEPTH, or DEPTH not a power of two, are illegal. Flag them with a simulation-time check.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - data_out = mem[rd_ptr] combinationally whenever !empty.
  - rd_valid = !empty.
  - rd acts as an acknowledge that pops the head word, with 0-cycle read latency.
  - Write-to-data_out latency is 1 cycle.
  - data_out is don't-care while empty.
- Not defined: registered read mode as specified above.
- All other behaviour, including flags, count and errors, is identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - clog2-style address-width function
  - error-flag bit positions (ERR_OVF=0, ERR_UNF=1) for status-register packing
- One sub-module, fifo_ram: a simple dual-port register array with one write port and one read port, asynchronous read, WIDTH × DEPTH.
- Pointer, count, flag and error logic live in sync_fifo_param.

Test Plan:
1. Reset, then write 0x01..0x10 with DEPTH=16. Expect: full=1 after the 16th write, count=16, almost_full=1 from count 14, overflow=0.
2. From full, one more write of 0xAA. Expect: overflow=1 and sticky; contents unchanged. Read all 16 → data_out sequence 0x01..0x10, each 1 cycle after rd with rd_valid=1. Then empty=1.
3. When empty, rd=1 → underflow=1, rd_valid=0. Pulse clr_err → both flags 0. Assert rd and clr_err together while empty → underflow stays 1.
4. With count=5, hold wr and rd for 40 cycles with incrementing data. Expect: count stays 5, output order preserved across pointer wrap, no flags.
5. At count=9, assert flush together with wr → next cycle count=0, empty=1, written word discarded, sticky flags unchanged. Drop rst_n mid-burst → immediate empty=1, data_out=0.
6. With SYNC_FIFO_FWFT_EN: write 0x3C at cycle N → data_out=0x3C and rd_valid=1 at N+1 without rd. Pop with rd → next word visible, or rd_valid=0 if empty.
